spi_master_ctrl: RTL
====================

Name: spi_master_ctrl

Overview:
Bench-side and on-chip-loopback SPI controller (initiator) that drives the register-mapped SPI responder of the design. It accepts single register read/write commands over a valid/ready handshake. It serialises each command as a 16-bit frame, MSB first: bit 15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = write data (zeros on read). Read data captured from MISO during the data byte is returned on a one-cycle response strobe.

Parameters:
CLK_DIV, 4, clk cycles per SPI half-period; legal range 2..255.
ADDR_WIDTH, 7, register address width; frame address field is fixed at 7 bits, so upper bits above 7 are ignored.
REG_WIDTH, 8, data byte width; fixed at 8 in this revision.
GAP_HALF, 2, minimum CS-high time between frames, in half-periods.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ena  in  1  clock enable; when low, all state, counters and outputs hold
mode  in  2  {cpol, cpha}; sampled at command accept
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  register address
cmd_wdata  in  REG_WIDTH  write data
rsp_valid  out  1  one-cycle pulse at end of every frame
rsp_rdata  out  REG_WIDTH  data byte captured from MISO; reads and writes both capture it
busy  out  1  high from accept until end of GAP
spi_cs_n  out  1  chip select, active low
spi_clk  out  1  SPI clock
spi_mosi  out  1  serial data out
spi_miso  in  1  serial data in

Behaviour:
- Reset values (asynchronous assertion, synchronous release to clk): state IDLE, spi_cs_n = 1, spi_clk = 0, spi_mosi = 0, rsp_valid = 0, rsp_rdata = 0, busy = 0, cmd_ready = 0 while rst is high.
- Reset mid-frame aborts immediately. No rsp_valid is produced for the aborted frame.
- Half-period tick: a divider counts 0..CLK_DIV-1 and asserts a tick on wrap. The counter clears on every state entry.
- IDLE:
  - spi_clk = latched cpol; spi_cs_n = 1.
  - Accept when cmd_valid & cmd_ready & ena: latch mode and the 16-bit frame, then go to SETUP.
- SETUP:
  - spi_cs_n = 0 from the first SETUP cycle.
  - For cpha = 0, spi_mosi = frame[15] during SETUP.
  - After 1 tick, go to SHIFT.
- SHIFT: 32 ticks, edge index e = 0..31. spi_clk toggles on each tick. Even e is the leading edge, odd e is the trailing edge.
  - cpha = 0: sample MISO on the leading edge; drive the next bit on the trailing edge (no drive after e = 31).
  - cpha = 1: drive the bit on the leading edge; sample MISO on the trailing edge.
  - Bits are sampled into a 16-bit shift register, MSB first.
  - After e = 31, go to HOLD.
- HOLD:
  - spi_clk is back at cpol; spi_cs_n = 0.
  - After 1 tick, go to DONE.
- DONE (single cycle):
  - spi_cs_n = 1.
  - rsp_rdata = low 8 sampled bits; rsp_valid = 1.
  - Go to GAP.
- GAP: spi_cs_n = 1 for GAP_HALF ticks, then go to IDLE. Back-to-back commands are therefore spaced by at least GAP_HALF half-periods.
- Latency, accept to rsp_valid: (1 + 32 + 1) × CLK_DIV + 1 clk cycles. For CLK_DIV = 4 this is 137.
- A cmd_valid deasserted before acceptance is not an error. Inputs are don't-care outside the accept cycle.
- A mode change while busy has no effect until the next accept.
- ena low freezes everything, including the divider. rsp_valid is held, not re-pulsed.

Optional Feature:
SPI_MASTER_MISO_SYNC_EN
- Defined:
  - spi_miso passes through a 2-flop synchronizer.
  - The capture point is delayed 2 clk cycles after the sampling edge tick, using the delayed value.
  - Requires CLK_DIV >= 3; an elaboration-time assertion enforces this.
  - Latency is unchanged, because HOLD covers the delay.
- Undefined: spi_miso is sampled directly on the edge tick.

Decomposition:
- Package spi_ctrl_pkg holds:
  - state enum {IDLE, SETUP, SHIFT, HOLD, DONE, GAP}
  - FRAME_BITS = 16
  - WRITE_BIT = 1
  - the frame-packing function {rw, addr[6:0], data}
- One sub-module: spi_clk_div (half-period tick generator with clear and ena), instantiated once.

Test Plan:
- Mode 0, CLK_DIV = 4, write addr 0x02 data 0xA5 -> MOSI bit stream 0x82A5, sampled by the bench model on rising edges; spi_cs_n low for 34 half-periods; rsp_valid exactly once at accept + 137 cycles.
- Mode 3, read addr 0x00, bench responder returns 0xCA in the data byte -> rsp_rdata = 0xCA; spi_clk idles high before and after the frame.
- Modes 1 and 2, read addr 0x01 returning 0x10 -> correct capture in both modes; no spi_clk glitch at SETUP/HOLD boundaries.
- cmd_valid held high for 3 commands -> cmd_ready low while busy; CS-high gap >= 2 × CLK_DIV cycles; three rsp_valid pulses in order.
- rst pulsed at SHIFT edge 10 -> next cycle spi_cs_n = 1, spi_clk = 0, no rsp_valid; a fresh command afterwards completes normally.
- ena low for 20 cycles mid-SHIFT -> spi_clk/spi_mosi frozen, total latency extended by exactly 20, data intact.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI initiator controller.
//   - spi_state_t : controller state encoding
//   - FRAME_BITS  : serial frame length (R/W + 7-bit address + data byte)
//   - WRITE_BIT   : value of the R/W bit that marks a write
//   - pack_frame  : builds the 16-bit frame {rw, addr[6:0], data[7:0]}
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4,
    GAP   = 3'd5
  } spi_state_t;

  localparam int   FRAME_BITS = 16;
  localparam logic WRITE_BIT  = 1'b1;

  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic       rw,
    input logic [6:0] addr,
    input logic [7:0] data
  );
    pack_frame = {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI initiator.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   ena  - clock enable; when low the counter holds
//   clr  - synchronous clear (qualified by ena), used on every state entry
//   tick - high for the cycle in which the counter sits at CLK_DIV-1
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_r;

  assign tick = ena && (cnt_r == CNT_LAST);

  // Divider counter: 0..CLK_DIV-1, wraps on tick, cleared on request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 8'd0;
    end else if (ena) begin
      if (clr || (cnt_r == CNT_LAST)) begin
        cnt_r <= 8'd0;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator that issues single register read/write commands to a
// register-mapped SPI responder. Each command becomes a 16-bit frame,
// MSB first: {R/W (1 = write), addr[6:0], wdata[7:0] (zero on reads)}.
// The byte clocked in from MISO during the data byte is returned on a
// one-cycle response strobe at the end of every frame.
//
// Ports:
//   clk, rst             - system clock, asynchronous active-high reset
//   ena                  - clock enable; low freezes all state and outputs
//   mode[1:0]            - {cpol, cpha}, captured when a command is accepted
//   cmd_valid/cmd_ready  - command handshake (ready only while idle)
//   cmd_write            - 1 = write, 0 = read
//   cmd_addr, cmd_wdata  - register address and write data
//   rsp_valid, rsp_rdata - end-of-frame strobe and captured data byte
//   busy                 - high from accept until the inter-frame gap ends
//   spi_cs_n, spi_clk, spi_mosi, spi_miso - SPI bus
//
// Build option:
//   SPI_MASTER_MISO_SYNC_EN - route spi_miso through a two-flop
//   synchronizer and capture the synchronized bit two cycles after the
//   sampling tick (needs CLK_DIV >= 3; HOLD absorbs the delay).
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int REG_WIDTH  = 8,
  parameter int GAP_HALF   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [1:0]            mode,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [REG_WIDTH-1:0]  cmd_wdata,
  output logic                  rsp_valid,
  output logic [REG_WIDTH-1:0]  rsp_rdata,
  output logic                  busy,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam logic [7:0] LAST_EDGE = 8'(2 * FRAME_BITS - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_HALF - 1);
  localparam logic       GAP_SKIP  = (GAP_HALF == 0);

  generate
    if ((CLK_DIV < 2) || (CLK_DIV > 255)) begin : g_bad_clk_div
      $error("spi_master_ctrl: CLK_DIV must be within 2..255");
    end
    if (REG_WIDTH != 8) begin : g_bad_reg_width
      $error("spi_master_ctrl: REG_WIDTH must be 8");
    end
`ifdef SPI_MASTER_MISO_SYNC_EN
    if (CLK_DIV < 3) begin : g_bad_sync_div
      $error("spi_master_ctrl: MISO synchronizer requires CLK_DIV >= 3");
    end
`endif
  endgenerate

  spi_state_t state_r;
  spi_state_t next_state_s;

  logic                  cpol_r;
  logic                  cpha_r;
  logic [FRAME_BITS-1:0] tx_r;
  logic [7:0]            rx_r;
  logic [7:0]            edge_r;
  logic                  spi_clk_r;
  logic                  spi_mosi_r;
  logic                  spi_cs_n_r;
  logic                  rsp_valid_r;
  logic [REG_WIDTH-1:0]  rsp_rdata_r;
  logic                  busy_r;
  logic                  cmd_ready_r;

  logic                  tick_s;
  logic                  clr_s;
  logic                  accept_s;
  logic                  lead_s;
  logic                  last_edge_s;
  logic                  shift_tick_s;
  logic                  drive_s;
  logic                  sample_s;
  logic                  capture_s;
  logic                  capture_bit_s;
  logic [6:0]            addr7_s;
  logic [7:0]            data_s;
  logic [FRAME_BITS-1:0] frame_s;

  // Only the low 7 address bits fit in the frame; wider addresses are cut.
  assign addr7_s  = 7'(cmd_addr);
  assign data_s   = (cmd_write == WRITE_BIT) ? 8'(cmd_wdata) : 8'h00;
  assign frame_s  = pack_frame(cmd_write, addr7_s, data_s);

  assign accept_s     = (state_r == IDLE) && cmd_valid && cmd_ready_r && ena;
  assign clr_s        = (next_state_s != state_r);
  assign lead_s       = ~edge_r[0];
  assign last_edge_s  = (edge_r == LAST_EDGE);
  assign shift_tick_s = tick_s && (state_r == SHIFT);
  // cpha=1 drives on leading edges; cpha=0 drives on trailing edges, except
  // after the final edge where there is no next bit.
  assign drive_s      = shift_tick_s &&
                        (cpha_r ? lead_s : (~lead_s && ~last_edge_s));
  assign sample_s     = shift_tick_s && (cpha_r ? ~lead_s : lead_s);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .clr  (clr_s),
    .tick (tick_s)
  );

`ifdef SPI_MASTER_MISO_SYNC_EN
  logic miso_s1_r;
  logic miso_s2_r;
  logic samp_d1_r;
  logic samp_d2_r;

  // MISO synchronizer and matching two-cycle delay of the sample strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_s1_r <= 1'b0;
      miso_s2_r <= 1'b0;
      samp_d1_r <= 1'b0;
      samp_d2_r <= 1'b0;
    end else if (ena) begin
      miso_s1_r <= spi_miso;
      miso_s2_r <= miso_s1_r;
      samp_d1_r <= sample_s;
      samp_d2_r <= samp_d1_r;
    end else begin
      miso_s1_r <= miso_s1_r;
      miso_s2_r <= miso_s2_r;
      samp_d1_r <= samp_d1_r;
      samp_d2_r <= samp_d2_r;
    end
  end

  assign capture_s     = samp_d2_r;
  assign capture_bit_s = miso_s2_r;
`else
  assign capture_s     = sample_s;
  assign capture_bit_s = spi_miso;
`endif

  // Next-state logic; every transition is qualified by ena
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = SETUP;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETUP: begin
        if (tick_s) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = SETUP;
        end
      end
      SHIFT: begin
        if (tick_s && last_edge_s) begin
          next_state_s = HOLD;
        end else begin
          next_state_s = SHIFT;
        end
      end
      HOLD: begin
        if (tick_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = HOLD;
        end
      end
      DONE: begin
        if (!ena) begin
          next_state_s = DONE;
        end else if (GAP_SKIP) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = GAP;
        end
      end
      GAP: begin
        if (tick_s && (edge_r == GAP_LAST)) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = GAP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register and status outputs derived from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      spi_cs_n_r  <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {REG_WIDTH{1'b0}};
    end else if (ena) begin
      state_r     <= next_state_s;
      cmd_ready_r <= (next_state_s == IDLE);
      busy_r      <= (next_state_s != IDLE);
      spi_cs_n_r  <= !((next_state_s == SETUP) || (next_state_s == SHIFT) ||
                       (next_state_s == HOLD));
      rsp_valid_r <= (next_state_s == DONE);
      if ((state_r == HOLD) && (next_state_s == DONE)) begin
        rsp_rdata_r <= REG_WIDTH'(rx_r);
      end else begin
        rsp_rdata_r <= rsp_rdata_r;
      end
    end else begin
      state_r     <= state_r;
      cmd_ready_r <= cmd_ready_r;
      busy_r      <= busy_r;
      spi_cs_n_r  <= spi_cs_n_r;
      rsp_valid_r <= rsp_valid_r;
      rsp_rdata_r <= rsp_rdata_r;
    end
  end

  // Edge index in SHIFT and half-period count in GAP, restarted on entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_r <= 8'd0;
    end else if (ena) begin
      if (clr_s) begin
        edge_r <= 8'd0;
      end else if (tick_s && ((state_r == SHIFT) || (state_r == GAP))) begin
        edge_r <= edge_r + 8'd1;
      end else begin
        edge_r <= edge_r;
      end
    end else begin
      edge_r <= edge_r;
    end
  end

  // Mode latch, SPI clock and MOSI shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      spi_clk_r  <= 1'b0;
      spi_mosi_r <= 1'b0;
      tx_r       <= {FRAME_BITS{1'b0}};
    end else if (ena) begin
      if (accept_s) begin
        cpol_r     <= mode[1];
        cpha_r     <= mode[0];
        spi_clk_r  <= mode[1];
        // MSB is presented at once; cpha=0 has already consumed it.
        spi_mosi_r <= frame_s[FRAME_BITS-1];
        tx_r       <= mode[0] ? frame_s : {frame_s[FRAME_BITS-2:0], 1'b0};
      end else begin
        cpol_r <= cpol_r;
        cpha_r <= cpha_r;
        if (shift_tick_s) begin
          spi_clk_r <= ~spi_clk_r;
        end else begin
          spi_clk_r <= spi_clk_r;
        end
        if (drive_s) begin
          spi_mosi_r <= tx_r[FRAME_BITS-1];
          tx_r       <= {tx_r[FRAME_BITS-2:0], 1'b0};
        end else begin
          spi_mosi_r <= spi_mosi_r;
          tx_r       <= tx_r;
        end
      end
    end else begin
      cpol_r     <= cpol_r;
      cpha_r     <= cpha_r;
      spi_clk_r  <= spi_clk_r;
      spi_mosi_r <= spi_mosi_r;
      tx_r       <= tx_r;
    end
  end

  // MISO capture, MSB first; the eight address-phase samples shift out the
  // top so only the data byte remains at the end of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_r <= 8'd0;
    end else if (ena && capture_s) begin
      rx_r <= {rx_r[6:0], capture_bit_s};
    end else begin
      rx_r <= rx_r;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign spi_cs_n  = spi_cs_n_r;
  assign spi_clk   = spi_clk_r;
  assign spi_mosi  = spi_mosi_r;

endmodule
